// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two bus masters sharing one single-port memory.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed cpu priority.
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_rw,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_rw,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          busy
);
    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam logic [LCW-1:0] LAT_LAST = LCW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e         state_q;
    logic [LCW-1:0] lat_cnt_q;
    logic           last_grant_q;
    logic           owner_q;
    logic           mem_en_q;
    logic           mem_rw_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic           r0_ack_q;
    logic           r1_ack_q;
    logic [DW-1:0]  r0_rdata_q;
    logic [DW-1:0]  r1_rdata_q;
    logic           grant_d;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // on a tie the master that lost last time goes next
        grant_d = (r0_req && r1_req) ? ~last_grant_q : ~r0_req;
`else
        // last_grant only shows through when nobody requests (grant unused)
        grant_d = ~r0_req & (r1_req | last_grant_q);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            r0_ack_q <= 1'b0;
            r1_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner_q     <= grant_d;
                        mem_addr_q  <= grant_d ? r1_addr : r0_addr;
                        mem_wdata_q <= grant_d ? r1_wdata : r0_wdata;
                        mem_rw_q    <= grant_d ? r1_rw : r0_rw;
                        mem_en_q    <= 1'b1;
                        lat_cnt_q   <= '0;
                        state_q     <= ACCESS;
                    end else begin
                        mem_en_q <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        if (mem_rw_q) begin
                            if (owner_q) r1_rdata_q <= mem_rdata;
                            else         r0_rdata_q <= mem_rdata;
                        end
                        mem_en_q <= 1'b0;
                        mem_rw_q <= 1'b1;
                        r0_ack_q <= ~owner_q;
                        r1_ack_q <= owner_q;
                        state_q  <= DONE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LCW'(1);
                    end
                end
                DONE: begin
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_ack    = r0_ack_q;
    assign r1_ack    = r1_ack_q;
    assign r0_rdata  = r0_rdata_q;
    assign r1_rdata  = r1_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: random two-master traffic on latencies 2, 1 and 15,
// checked cycle by cycle against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int NK = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rq   [NK][2];
    logic        rrw  [NK][2];
    logic [31:0] rad  [NK][2];
    logic [31:0] rwd  [NK][2];
    logic        ack  [NK][2];
    logic [31:0] rdat [NK][2];
    logic        men    [NK];
    logic        mrw    [NK];
    logic        own_o  [NK];
    logic        busy_o [NK];
    logic [31:0] mad    [NK];
    logic [31:0] mwd    [NK];
    logic [31:0] mrd    [NK];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {16'hCAFE ^ {12'h0, a[3:0]}, a[19:4]};
    endfunction

    function automatic int latof(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < NK; g++) begin : gd
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        int en_cnt;

        mem_bus_arbiter #(
            .AW(32), .DW(32), .MEM_LAT(L)
        ) u_dut (
            .clock    (clk),
            .reset    (rst_n),
            .r0_req   (rq[g][0]),
            .r0_rw    (rrw[g][0]),
            .r0_addr  (rad[g][0]),
            .r0_wdata (rwd[g][0]),
            .r0_ack   (ack[g][0]),
            .r0_rdata (rdat[g][0]),
            .r1_req   (rq[g][1]),
            .r1_rw    (rrw[g][1]),
            .r1_addr  (rad[g][1]),
            .r1_wdata (rwd[g][1]),
            .r1_ack   (ack[g][1]),
            .r1_rdata (rdat[g][1]),
            .mem_en   (men[g]),
            .mem_rw   (mrw[g]),
            .mem_addr (mad[g]),
            .mem_wdata(mwd[g]),
            .mem_rdata(mrd[g]),
            .owner    (own_o[g]),
            .busy     (busy_o[g])
        );

        // memory returns real data only in the last cycle of the enable window
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) en_cnt <= 0;
            else        en_cnt <= men[g] ? en_cnt + 1 : 0;
        end
        assign mrd[g] = (men[g] && en_cnt == L - 1) ? memf(mad[g]) : 32'hDEAD_BEEF;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int k,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[lat%0d] got=%h exp=%h t=%0t",
                     tag, latof(k), got, exp, $time);
        end
    endtask

    // reference model: one record of the transaction in flight per DUT
    int          e;
    int          G      [NK];
    bit          act    [NK];
    bit          m_own  [NK];
    bit          m_rw   [NK];
    bit          lastg  [NK];
    logic [31:0] m_ad   [NK];
    logic [31:0] m_wd   [NK];
    logic [31:0] erd    [NK][2];

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            act[k]    = 1'b0;
            G[k]      = 0;
            lastg[k]  = 1'b1;
            erd[k][0] = '0;
            erd[k][1] = '0;
        end
    endtask

    task automatic model_edge(input int k);
        int L;
        int d;
        int w;
        L = latof(k);
        d = e - G[k];
        if (act[k] && d == L && m_rw[k]) erd[k][m_own[k]] = memf(m_ad[k]);
        if (act[k] && d >= L + 2) act[k] = 1'b0;
        if (!act[k] && (rq[k][0] || rq[k][1])) begin
            if (rq[k][0] && rq[k][1]) begin
`ifdef MEM_ARB_RR_EN
                w = lastg[k] ? 0 : 1;
`else
                w = 0;
`endif
            end else begin
                w = rq[k][0] ? 0 : 1;
            end
            act[k]   = 1'b1;
            G[k]     = e;
            m_own[k] = w[0];
            lastg[k] = w[0];
            m_rw[k]  = rrw[k][w];
            m_ad[k]  = rad[k][w];
            m_wd[k]  = rwd[k][w];
        end
    endtask

    task automatic check_outs(input int k);
        int L;
        int d;
        bit en;
        bit bz;
        bit ak;
        L  = latof(k);
        d  = e - G[k];
        en = act[k] && d < L;
        bz = act[k] && d <= L;
        ak = act[k] && d == L;
        chk("mem_en", k, men[k], en);
        chk("busy", k, busy_o[k], bz);
        chk("ack0", k, ack[k][0], ak && !m_own[k]);
        chk("ack1", k, ack[k][1], ak && m_own[k]);
        chk("mem_rw", k, mrw[k], en ? m_rw[k] : 1'b1);
        chk("rdata0", k, rdat[k][0], erd[k][0]);
        chk("rdata1", k, rdat[k][1], erd[k][1]);
        if (bz) chk("owner", k, own_o[k], m_own[k]);
        if (en) begin
            chk("mem_addr", k, mad[k], m_ad[k]);
            chk("mem_wdata", k, mwd[k], m_wd[k]);
        end
    endtask

    task automatic check_reset_vals();
        for (int k = 0; k < NK; k++) begin
            chk("rst_mem_en", k, men[k], 0);
            chk("rst_mem_rw", k, mrw[k], 1);
            chk("rst_mem_addr", k, mad[k], 0);
            chk("rst_mem_wdata", k, mwd[k], 0);
            chk("rst_owner", k, own_o[k], 0);
            chk("rst_busy", k, busy_o[k], 0);
            chk("rst_ack0", k, ack[k][0], 0);
            chk("rst_ack1", k, ack[k][1], 0);
            chk("rst_rdata0", k, rdat[k][0], 0);
            chk("rst_rdata1", k, rdat[k][1], 0);
        end
    endtask

    task automatic new_fields(input int k, input int m);
        rrw[k][m] = 1'($urandom_range(0, 1));
        rad[k][m] = $urandom & 32'h000F_FFFC;
        rwd[k][m] = $urandom;
    endtask

    task automatic agent(input int k, input int m, input bit hold);
        bit ak;
        ak = act[k] && (e - G[k]) == latof(k) && m_own[k] == m[0];
        if (rq[k][m]) begin
            if (ak) begin
                if (hold || $urandom_range(0, 2) == 0) new_fields(k, m);
                else rq[k][m] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                new_fields(k, m);
            end
        end else if (hold || $urandom_range(0, 99) < 30) begin
            rq[k][m] = 1'b1;
            new_fields(k, m);
        end
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
    endtask

    bit want_rst = 1'b0;
    bit hold_all;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NK; k++) begin
            for (int m = 0; m < 2; m++) begin
                rq[k][m]  = 1'b0;
                rrw[k][m] = 1'b1;
                rad[k][m] = '0;
                rwd[k][m] = '0;
            end
        end
        model_reset();
        e = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_vals();
        @(negedge clk) rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            e++;
            for (int k = 0; k < NK; k++) model_edge(k);
            for (int k = 0; k < NK; k++) check_outs(k);
            if (c == 1700 || c == 2300) want_rst = 1'b1;
            if (want_rst && act[0] && e == G[0]) begin
                mid_reset();
                want_rst = 1'b0;
            end
            hold_all = (c >= 1000 && c < 1500);
            for (int k = 0; k < NK; k++) begin
                for (int m = 0; m < 2; m++) agent(k, m, hold_all);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
